// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for the pipeline registers
// Purpose: datapath width, the NOP instruction word and the PC increment
//          used by the fetch/decode pipeline stages.
// Ports:   none (package).
package cpu_pkg;

  localparam int          XLEN      = 32;
  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with asynchronous clear
// Purpose: counts cycles where both en_i and inc_i are high; sticks at all-ones.
// Ports:
//   clk_i  in   1      clock, rising edge
//   rst_i  in   1      asynchronous clear, active-low
//   en_i   in   1      global enable; 0 freezes the count
//   inc_i  in   1      event to count
//   cnt_o  out  CNT_W  current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (en_i && inc_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with stall hold, flush bubble and event counters
// Purpose: latches the fetched instruction, its PC and PC+4 for decode; holds on a
//          hazard stall, squashes to a NOP bubble on a branch/jump flush, and counts
//          accepted stalls and flushes (saturating).
// Ports:
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      asynchronous reset, active-low
//   start_i      in   1      run enable; 0 freezes register and counters
//   stall_i      in   1      load-use stall; hold contents
//   flush_i      in   1      taken branch/jump; insert bubble
//   pc_i         in   XLEN   PC of the instruction in IF
//   instr_i      in   XLEN   fetched instruction for pc_i
//   pc_o         out  XLEN   PC of the instruction in ID
//   pc_plus4_o   out  XLEN   pc_o + 4 (modulo 2^XLEN)
//   instr_o      out  XLEN   instruction in ID
//   valid_o      out  1      1 = real instruction, 0 = bubble
//   stall_cnt_o  out  CNT_W  accepted stall cycles
//   flush_cnt_o  out  CNT_W  accepted flush cycles
module if_id_reg #(
  parameter int                    XLEN  = cpu_pkg::XLEN,
  parameter int                    CNT_W = 16,
  parameter logic [XLEN-1:0]       NOP   = XLEN'(cpu_pkg::NOP_INSTR)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  instr_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic [XLEN-1:0]  instr_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  import cpu_pkg::*;

  logic [XLEN-1:0] pc_next_seq;
  logic            stall_accepted;

  // Truncating add: the carry out of the top bit is intentionally dropped.
  assign pc_next_seq    = pc_i + XLEN'(PC_INC);
  // A flush takes priority, so a simultaneous stall is not counted.
  assign stall_accepted = stall_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o       <= '0;
      pc_plus4_o <= '0;
      instr_o    <= NOP;
      valid_o    <= 1'b0;
    end else if (!start_i) begin
      // frozen: hold everything
    end else if (flush_i) begin
      pc_o       <= pc_i;
      pc_plus4_o <= pc_next_seq;
      instr_o    <= NOP;
      valid_o    <= 1'b0;
    end else if (!stall_i) begin
      pc_o       <= pc_i;
      pc_plus4_o <= pc_next_seq;
      instr_o    <= instr_i;
      valid_o    <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (start_i),
    .inc_i (stall_accepted),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (start_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );

endmodule : if_id_reg

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - self-checking bench for if_id_reg
module tb_if_id_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i, flush_i;
  logic [31:0] pc_i, instr_i;

  logic [31:0] pc_o, pc_plus4_o, instr_o;
  logic        valid_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic [31:0] s_pc_o, s_pc_plus4_o, s_instr_o;
  logic        s_valid_o;
  logic [1:0]  s_stall_cnt_o, s_flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  if_id_reg #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .instr_i(instr_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_o(instr_o),
    .valid_o(valid_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  if_id_reg #(.XLEN(32), .CNT_W(2)) dut_small (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .instr_i(instr_i), .pc_o(s_pc_o), .pc_plus4_o(s_pc_plus4_o), .instr_o(s_instr_o),
    .valid_o(s_valid_o), .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: architectural state of the decode slot plus plain event tallies.
  longint m_pc = 0, m_p4 = 0, m_instr = 0;
  int     m_valid = 0;
  int     m_stalls = 0, m_flushes = 0;

  function automatic longint sat(input int n, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (n > lim) ? lim : longint'(n);
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_pc = 0; m_p4 = 0; m_instr = 0; m_valid = 0; m_stalls = 0; m_flushes = 0;
    end else if (start_i) begin
      if (flush_i) begin
        m_pc = pc_i; m_p4 = (longint'(pc_i) + 4) % 64'h1_0000_0000;
        m_instr = 0; m_valid = 0; m_flushes++;
      end else if (stall_i) begin
        m_stalls++;
      end else begin
        m_pc = pc_i; m_p4 = (longint'(pc_i) + 4) % 64'h1_0000_0000;
        m_instr = instr_i; m_valid = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk_i) begin
    if (!done) begin
      chk("m.pc",        pc_o,                 32'(m_pc));
      chk("m.pc_plus4",  pc_plus4_o,           32'(m_p4));
      chk("m.instr",     instr_o,              32'(m_instr));
      chk("m.valid",     32'(valid_o),         32'(m_valid));
      chk("m.stall_cnt", 32'(stall_cnt_o),     32'(sat(m_stalls, 16)));
      chk("m.flush_cnt", 32'(flush_cnt_o),     32'(sat(m_flushes, 16)));
      chk("m.s_pc",      s_pc_o,               32'(m_pc));
      chk("m.s_valid",   32'(s_valid_o),       32'(m_valid));
      chk("m.s_stall",   32'(s_stall_cnt_o),   32'(sat(m_stalls, 2)));
      chk("m.s_flush",   32'(s_flush_cnt_o),   32'(sat(m_flushes, 2)));
    end
  end

  // Apply inputs just after an edge, then advance to 1 time unit past the next edge.
  task automatic step(input logic st, input logic sl, input logic fl,
                      input logic [31:0] pc, input logic [31:0] ins);
    start_i = st; stall_i = sl; flush_i = fl; pc_i = pc; instr_i = ins;
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    pc_i = 32'h0; instr_i = 32'h0;
    #2;
    chk("rst.pc",    pc_o, 32'h0);
    chk("rst.instr", instr_o, 32'h0);
    chk("rst.valid", 32'(valid_o), 32'h0);
    chk("rst.cnt",   32'(stall_cnt_o) | 32'(flush_cnt_o), 32'h0);
    #10 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // normal flow
    step(1, 0, 0, 32'h40, 32'h8C22_0004);
    chk("load.pc",    pc_o,       32'h40);
    chk("load.p4",    pc_plus4_o, 32'h44);
    chk("load.instr", instr_o,    32'h8C22_0004);
    chk("load.valid", 32'(valid_o), 32'h1);

    // three stalls with changing inputs
    step(1, 1, 0, 32'h44, 32'h1111_1111);
    step(1, 1, 0, 32'h48, 32'h2222_2222);
    step(1, 1, 0, 32'h4C, 32'h3333_3333);
    chk("stall.pc",    pc_o,    32'h40);
    chk("stall.instr", instr_o, 32'h8C22_0004);
    chk("stall.cnt",   32'(stall_cnt_o), 32'd3);
    step(1, 0, 0, 32'h50, 32'hAAAA_5555);
    chk("resume.pc",    pc_o,    32'h50);
    chk("resume.instr", instr_o, 32'hAAAA_5555);

    // flush wins over stall
    step(1, 1, 1, 32'h80, 32'hDEAD_BEEF);
    chk("flush.instr", instr_o, 32'h0);
    chk("flush.valid", 32'(valid_o), 32'h0);
    chk("flush.pc",    pc_o,    32'h80);
    chk("flush.fcnt",  32'(flush_cnt_o), 32'd1);
    chk("flush.scnt",  32'(stall_cnt_o), 32'd3);

    // stalled bubble stays a bubble; small counter saturates after 5 stalls
    step(1, 1, 0, 32'h90, 32'h1234_5678);
    step(1, 1, 0, 32'h94, 32'h1234_5679);
    chk("bubble.valid", 32'(valid_o), 32'h0);
    chk("bubble.instr", instr_o, 32'h0);
    chk("sat.small",    32'(s_stall_cnt_o), 32'd3);
    chk("sat.big",      32'(stall_cnt_o),   32'd5);

    // pc+4 wraps
    step(1, 0, 0, 32'hFFFF_FFFC, 32'h0000_0013);
    chk("wrap.p4", pc_plus4_o, 32'h0);

    // start_i low freezes everything
    step(0, 1, 1, 32'h100, 32'h55);
    step(0, 0, 0, 32'h104, 32'h56);
    chk("frz.pc",    pc_o, 32'hFFFF_FFFC);
    chk("frz.instr", instr_o, 32'h13);
    chk("frz.scnt",  32'(stall_cnt_o), 32'd5);
    chk("frz.fcnt",  32'(flush_cnt_o), 32'd1);
    step(1, 0, 0, 32'h108, 32'h66);
    chk("run.pc", pc_o, 32'h108);

    // repeated flushes saturate the small flush counter
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'h200 + 32'(4 * i), 32'h77);
    chk("fsat.small", 32'(s_flush_cnt_o), 32'd3);
    chk("fsat.big",   32'(flush_cnt_o),   32'd5);

    // unaligned pc passes through
    step(1, 0, 0, 32'h123, 32'h7);
    chk("unal.pc", pc_o, 32'h123);
    chk("unal.p4", pc_plus4_o, 32'h127);

    // async reset mid-cycle with junk inputs
    #2;
    pc_i = 32'hCAFE_F00D; instr_i = 32'hBAD0_BAD0; stall_i = 1'b1; flush_i = 1'b1;
    rst_i = 1'b0;
    #1;
    chk("arst.pc",    pc_o, 32'h0);
    chk("arst.p4",    pc_plus4_o, 32'h0);
    chk("arst.instr", instr_o, 32'h0);
    chk("arst.valid", 32'(valid_o), 32'h0);
    chk("arst.cnt",   32'(stall_cnt_o) | 32'(flush_cnt_o), 32'h0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    step(1, 0, 0, 32'h300, 32'h0042_0020);
    chk("post.instr", instr_o, 32'h0042_0020);
    chk("post.valid", 32'(valid_o), 32'h1);

    @(negedge clk_i); #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule : tb_if_id_reg
